// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder: synchronize a Gray count, convert to binary, classify each change as up/down/illegal
module gray_rx_decoder #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] g_in,
    input  logic         en,
    input  logic         clr_err,
    output logic [W-1:0] bin_out,
    output logic         valid,
    output logic         step_up,
    output logic         step_dn,
    output logic         err,
    output logic [7:0]   err_cnt
);
    typedef enum logic {INIT, TRACK} state_t;
    localparam int FW = $clog2(SYNC_STAGES + 1);
    state_t         state_q, state_d;
    logic [W-1:0]   sync_q [SYNC_STAGES];
    logic [W-1:0]   g_s, b, diff;
    logic [FW-1:0]  fill_q;
    logic           filled;
    logic [W-1:0]   prev_b_q, prev_b_d;
    logic           valid_q, valid_d;
    logic           step_up_q, step_up_d;
    logic           step_dn_q, step_dn_d;
    logic           err_q, err_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    assign g_s    = sync_q[SYNC_STAGES-1];
    assign filled = fill_q == FW'(SYNC_STAGES);
    assign diff   = b - prev_b_q;
    for (genvar i = 0; i < W; i++) begin : g_conv
        assign b[i] = ^(g_s >> i);
    end
    // synchronizer chain into the local clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= g_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
    // count edges since reset so the baseline is taken from a real sample, not the reset zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fill_q <= '0;
        else if (!filled) fill_q <= fill_q + 1'b1;
    end
    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= INIT;
        else state_q <= state_d;
    end
    // FSM next state: leave INIT once a filled sample is accepted
    always_comb begin
        state_d = state_q;
        if (state_q == INIT && en && filled) state_d = TRACK;
    end
    // FSM outputs: baseline capture, step classification and error counting
    always_comb begin
        prev_b_d  = prev_b_q;
        valid_d   = valid_q;
        step_up_d = 1'b0;
        step_dn_d = 1'b0;
        err_d     = 1'b0;
        if (en && state_q == INIT && filled) begin
            prev_b_d = b;
            valid_d  = 1'b1;
        end else if (en && state_q == TRACK && diff != '0) begin
            prev_b_d  = b;
            step_up_d = diff == W'(1);
            step_dn_d = diff == {W{1'b1}};
            err_d     = diff != W'(1) && diff != {W{1'b1}};
        end
        err_cnt_d = clr_err ? 8'd0 : (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end
    // registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_b_q  <= '0;
            valid_q   <= 1'b0;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            prev_b_q  <= prev_b_d;
            valid_q   <= valid_d;
            step_up_q <= step_up_d;
            step_dn_q <= step_dn_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end
    assign bin_out = prev_b_q;
    assign valid   = valid_q;
    assign step_up = step_up_q;
    assign step_dn = step_dn_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
endmodule
